acc_alu_seq: RTL and testbench

Parametrised, registered accumulator ALU: the sequential successor of the combinational accumulator ALU. It holds the accumulator and the carry, zero, negative and overflow flags internally, and it executes multi-cycle shift and multiply operations behind a start/busy/done handshake. It sits between the controller (which issues `op` plus operand) and the register file or data memory path (which supplies `in_a`). It lets the datapath grow beyond 8 bits and beyond single-cycle ops.

---
 rtl/acc_alu_seq.sv | 153 +++++++++++++++
 tb/tb_acc_alu_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_seq.sv
// Registered accumulator ALU with carry/zero/sign/overflow flags.
// Shifts step one bit per cycle and MUL is a W-step shift-add, both behind busy/done.
module acc_alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] in_a,
  output logic [W-1:0] acc,
  output logic         c,
  output logic         z,
  output logic         neg,
  output logic         v,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]  W_A = W'(W);
  localparam logic [CW-1:0] W_C = CW'(W);

  localparam logic [3:0] OP_ADD = 4'h1, OP_ADC = 4'h2, OP_SUB = 4'h3, OP_SBC = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_NOT = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9, OP_CLR = 4'hA, OP_SHL = 4'hB, OP_SHR = 4'hC;
  localparam logic [3:0] OP_ASR = 4'hD, OP_MUL = 4'hE;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t        state_q;
  logic [W-1:0]  acc_q, work_q, mcand_q, mhi_q, mlo_q;
  logic          c_q, v_q, done_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    sop_q;

  // Returns {overflow, carry, sum} of a + b + cin.
  function automatic logic [W+1:0] add_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s};
  endfunction

  // One-bit shift; sop is op[1:0]: 11 SHL, 00 SHR, 01 ASR. Returns {bit_out, result}.
  function automatic logic [W:0] shift1(input logic [1:0] sop, input logic [W-1:0] x);
    case (sop)
      2'b11:   return {x[W-1], x[W-2:0], 1'b0};
      2'b00:   return {x[0], 1'b0, x[W-1:1]};
      default: return {x[0], x[W-1], x[W-1:1]};
    endcase
  endfunction

  logic [CW-1:0] k;
  logic          is_shift, multi_start;
  logic          sh_out;
  logic [W-1:0]  sh_next;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mhi_n, mlo_n;

  always_comb begin
    k           = (in_a >= W_A) ? W_C : in_a[CW-1:0];
    is_shift    = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    multi_start = (is_shift && (k != '0)) || (op == OP_MUL);
    {sh_out, sh_next} = shift1(sop_q, work_q);
    mul_sum     = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, mcand_q} : '0);
    mhi_n       = mul_sum[W:1];
    mlo_n       = {mul_sum[0], mlo_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sop_q   <= '0;
      work_q  <= '0;
      mcand_q <= '0;
      mhi_q   <= '0;
      mlo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          done_q <= !multi_start;
          case (op)
            OP_ADD: {v_q, c_q, acc_q} <= add_ovf(acc_q, in_a, 1'b0);
            OP_ADC: {v_q, c_q, acc_q} <= add_ovf(acc_q, in_a, c_q);
            OP_SUB: {v_q, c_q, acc_q} <= add_ovf(acc_q, ~in_a, 1'b1);
            OP_SBC: {v_q, c_q, acc_q} <= add_ovf(acc_q, ~in_a, c_q);
            OP_AND: begin acc_q <= acc_q & in_a; v_q <= 1'b0; end
            OP_OR:  begin acc_q <= acc_q | in_a; v_q <= 1'b0; end
            OP_XOR: begin acc_q <= acc_q ^ in_a; v_q <= 1'b0; end
            OP_NOT: begin acc_q <= ~acc_q;       v_q <= 1'b0; end
            OP_LDI: begin acc_q <= in_a;         v_q <= 1'b0; end
            OP_CLR: begin acc_q <= '0; c_q <= 1'b0; v_q <= 1'b0; end
            OP_SHL, OP_SHR, OP_ASR: if (k != '0) begin
              state_q <= SHIFT;
              work_q  <= acc_q;
              cnt_q   <= k;
              sop_q   <= op[1:0];
            end
            OP_MUL: begin
              state_q <= MUL;
              mcand_q <= acc_q;
              mlo_q   <= in_a;
              mhi_q   <= '0;
              cnt_q   <= W_C;
            end
            default: ;
          endcase
        end
        // Working register shifts each cycle; acc only commits on the last step.
        SHIFT: begin
          work_q <= sh_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            acc_q   <= sh_next;
            c_q     <= sh_out;
            v_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        MUL: begin
          mhi_q <= mhi_n;
          mlo_q <= mlo_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            acc_q   <= mlo_n;
            c_q     <= |mhi_n;
            v_q     <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign acc  = acc_q;
  assign c    = c_q;
  assign v    = v_q;
  assign z    = (acc_q == '0);
  assign neg  = acc_q[W-1];
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Bench for acc_alu_seq at W=8: directed vectors, busy-ignore, back-to-back,
// random ops against an integer-arithmetic model, and asynchronous reset mid-MUL.
module tb_acc_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [3:0] op;
  logic [7:0] in_a;
  logic [7:0] acc;
  logic       c, z, neg, v, busy, done;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_acc;
  logic       m_c, m_v;

  always #5 clk = ~clk;

  acc_alu_seq #(.W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .in_a(in_a),
    .acc(acc), .c(c), .z(z), .neg(neg), .v(v), .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] acc;
    logic [3:0] f;    // {c, z, neg, v}
    int         lat;
  } vec_t;

  // Model: applies an op using plain integer arithmetic; returns expected latency.
  task automatic model_apply(input logic [3:0] o, input logic [7:0] a, output int exp_lat);
    int ua, uacc, sa, sacc, t, ss, k;
    ua = int'(a); uacc = int'(m_acc);
    sa = int'($signed(a)); sacc = int'($signed(m_acc));
    exp_lat = 0;
    case (o)
      4'h1: begin t = uacc + ua; ss = sacc + sa; end
      4'h2: begin t = uacc + ua + int'(m_c); ss = sacc + sa + int'(m_c); end
      4'h3: begin t = uacc + (255 - ua) + 1; ss = sacc - sa; end
      4'h4: begin t = uacc + (255 - ua) + int'(m_c); ss = sacc - sa - 1 + int'(m_c); end
      default: begin t = 0; ss = 0; end
    endcase
    case (o)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        m_acc = t[7:0]; m_c = (t > 255); m_v = (ss > 127) || (ss < -128);
      end
      4'h5: begin m_acc = m_acc & a; m_v = 1'b0; end
      4'h6: begin m_acc = m_acc | a; m_v = 1'b0; end
      4'h7: begin m_acc = m_acc ^ a; m_v = 1'b0; end
      4'h8: begin m_acc = ~m_acc;    m_v = 1'b0; end
      4'h9: begin m_acc = a;         m_v = 1'b0; end
      4'hA: begin m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0; end
      4'hB, 4'hC, 4'hD: begin
        k = (ua > 8) ? 8 : ua;
        if (k > 0) begin
          exp_lat = k;
          m_v = 1'b0;
          if (o == 4'hB) begin m_c = m_acc[8-k]; m_acc = m_acc << k; end
          else if (o == 4'hC) begin m_c = m_acc[k-1]; m_acc = m_acc >> k; end
          else begin m_c = ((sacc >>> (k - 1)) & 1) != 0; t = sacc >>> k; m_acc = t[7:0]; end
        end
      end
      4'hE: begin
        t = uacc * ua; m_acc = t[7:0]; m_c = ((t >> 8) != 0); m_v = 1'b0; exp_lat = 8;
      end
      default: ;
    endcase
  endtask

  // Issues one op and waits (bounded) for done; reports edges after E0 and busy cycles.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, output int lat,
                       output int bcnt, output logic busy_at_done, output int exp_lat);
    model_apply(o, a, exp_lat);
    @(negedge clk);
    start = 1'b1; op = o; in_a = a;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = busy;
  endtask

  task automatic test_reset;
    checks++;
    if ({acc, c, z, neg, v, busy, done} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {acc, c, z, neg, v, busy, done},
               {8'h00, 6'b010000});
    end
  endtask

  task automatic test_directed;
    vec_t tv[$];
    int lat, bcnt, el;
    logic bd;
    tv.push_back(vec_t'{4'h9, 8'h7F, 8'h7F, 4'b0000, 0});
    tv.push_back(vec_t'{4'h1, 8'h01, 8'h80, 4'b0011, 0});
    tv.push_back(vec_t'{4'h9, 8'hFF, 8'hFF, 4'b0010, 0});
    tv.push_back(vec_t'{4'h1, 8'h01, 8'h00, 4'b1100, 0});
    tv.push_back(vec_t'{4'h2, 8'h00, 8'h01, 4'b0000, 0});
    tv.push_back(vec_t'{4'h9, 8'h05, 8'h05, 4'b0000, 0});
    tv.push_back(vec_t'{4'h3, 8'h07, 8'hFE, 4'b0010, 0});
    tv.push_back(vec_t'{4'h4, 8'h00, 8'hFD, 4'b1010, 0});
    tv.push_back(vec_t'{4'h9, 8'h81, 8'h81, 4'b1010, 0});
    tv.push_back(vec_t'{4'hB, 8'h03, 8'h08, 4'b0000, 3});
    tv.push_back(vec_t'{4'h9, 8'h90, 8'h90, 4'b0010, 0});
    tv.push_back(vec_t'{4'hD, 8'h02, 8'hE4, 4'b0010, 2});
    tv.push_back(vec_t'{4'hB, 8'h09, 8'h00, 4'b0100, 8});
    tv.push_back(vec_t'{4'h9, 8'h0C, 8'h0C, 4'b0000, 0});
    tv.push_back(vec_t'{4'hE, 8'h15, 8'hFC, 4'b0010, 8});
    tv.push_back(vec_t'{4'h9, 8'h10, 8'h10, 4'b0000, 0});
    tv.push_back(vec_t'{4'hE, 8'h10, 8'h00, 4'b1100, 8});
    tv.push_back(vec_t'{4'hA, 8'h55, 8'h00, 4'b0100, 0});
    tv.push_back(vec_t'{4'h9, 8'h80, 8'h80, 4'b0010, 0});
    tv.push_back(vec_t'{4'hB, 8'h00, 8'h80, 4'b0010, 0});
    tv.push_back(vec_t'{4'h8, 8'h00, 8'h7F, 4'b0000, 0});
    tv.push_back(vec_t'{4'hF, 8'hAA, 8'h7F, 4'b0000, 0});
    foreach (tv[i]) begin
      issue(tv[i].op, tv[i].a, lat, bcnt, bd, el);
      checks++;
      if ({acc, c, z, neg, v} !== {tv[i].acc, tv[i].f}) begin
        errors++;
        $display("FAIL directed[%0d] op=%h got acc=%h czNv=%b exp acc=%h czNv=%b",
                 i, tv[i].op, acc, {c, z, neg, v}, tv[i].acc, tv[i].f);
      end
      checks++;
      if (lat !== tv[i].lat || bcnt !== tv[i].lat || bd !== 1'b0) begin
        errors++;
        $display("FAIL directed_timing[%0d] got lat=%0d busy=%0d busy@done=%b exp lat=busy=%0d busy@done=0",
                 i, lat, bcnt, bd, tv[i].lat);
      end
    end
  endtask

  task automatic test_ignore_busy;
    int lat, bcnt, el;
    logic bd;
    issue(4'h9, 8'h03, lat, bcnt, bd, el);
    model_apply(4'hE, 8'h05, el);
    @(negedge clk);
    start = 1'b1; op = 4'hE; in_a = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 3); op = 4'h1; in_a = 8'h11;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if ({acc, c, lat} !== {8'h0F, 1'b0, 32'd8}) begin
      errors++;
      $display("FAIL ignore_busy got acc=%h c=%b lat=%0d exp acc=0f c=0 lat=8", acc, c, lat);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, acc} !== {1'b0, 1'b0, 8'h0F}) begin
      errors++;
      $display("FAIL ignore_busy_after got done=%b busy=%b acc=%h exp 0 0 0f", done, busy, acc);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, el;
    logic bd;
    issue(4'h9, 8'h11, lat, bcnt, bd, el);
    issue(4'h1, 8'h22, lat, bcnt, bd, el);
    checks++;
    if ({acc, lat} !== {8'h33, 32'd0}) begin
      errors++;
      $display("FAIL b2b_single got acc=%h lat=%0d exp acc=33 lat=0", acc, lat);
    end
    issue(4'hC, 8'h01, lat, bcnt, bd, el);
    issue(4'hB, 8'h02, lat, bcnt, bd, el);
    checks++;
    if ({acc, c, lat} !== {8'h64, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL b2b_shift got acc=%h c=%b lat=%0d exp acc=64 c=0 lat=2", acc, c, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b exp 0", done);
    end
  endtask

  task automatic test_random;
    int lat, bcnt, el;
    logic bd;
    logic [3:0] o;
    logic [7:0] a;
    for (int n = 0; n < 300; n++) begin
      o = 4'($urandom_range(0, 15));
      a = (o >= 4'hB && o <= 4'hD) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      issue(o, a, lat, bcnt, bd, el);
      checks++;
      if ({acc, c, z, neg, v} !== {m_acc, m_c, (m_acc == 8'h00), m_acc[7], m_v} || lat != el) begin
        errors++;
        $display("FAIL random[%0d] op=%h a=%h got acc=%h czNv=%b lat=%0d exp acc=%h czNv=%b lat=%0d",
                 n, o, a, acc, {c, z, neg, v}, lat, m_acc,
                 {m_c, (m_acc == 8'h00), m_acc[7], m_v}, el);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat, bcnt, el;
    logic bd;
    issue(4'h9, 8'hA5, lat, bcnt, bd, el);
    @(negedge clk);
    start = 1'b1; op = 4'hE; in_a = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_mul_busy got busy=%b exp 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({acc, c, z, neg, v, busy, done} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", {acc, c, z, neg, v, busy, done},
               {8'h00, 6'b010000});
    end
    m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'h9, 8'h3C, lat, bcnt, bd, el);
    checks++;
    if ({acc, c, busy, lat} !== {8'h3C, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset_ldi got acc=%h c=%b busy=%b lat=%0d exp acc=3c c=0 busy=0 lat=0",
               acc, c, busy, lat);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 4'h0; in_a = 8'h00;
    m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0;
    #12;
    test_reset;
    @(negedge clk);
    reset_n = 1'b1;
    test_directed;
    test_ignore_busy;
    test_back_to_back;
    test_random;
    test_reset_mid_mul;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
